// File: rtl/processor.sv
// 8-bit accumulator CPU with a 256-byte unified memory loaded and inspected through a user port.
// Define PROCESSOR_BRANCH_EN to implement JMP/JZ; otherwise 0x1d/0x1e execute as 1-byte NOPs.
module processor (
    input  logic       clk,
    input  logic       reset,
    input  logic       op,
    input  logic [7:0] in_data,
    input  logic       user_write_memory,
    input  logic [7:0] user_address,
    output logic [7:0] out_data,
    output logic [7:0] acc_out,
    output logic [7:0] pc_out,
    output logic       halted
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_OPERAND, S_EXEC, S_HALT} state_t;

    localparam logic [7:0] OP_HLT  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h0c;
    localparam logic [7:0] OP_SUB  = 8'h0d;
    localparam logic [7:0] OP_AND  = 8'h0e;
    localparam logic [7:0] OP_XOR  = 8'h0f;
    localparam logic [7:0] OP_MVIA = 8'h18;
    localparam logic [7:0] OP_MVIB = 8'h19;
    localparam logic [7:0] OP_LDA  = 8'h1a;
    localparam logic [7:0] OP_STA  = 8'h1c;
    localparam logic [7:0] OP_JMP  = 8'h1d;
    localparam logic [7:0] OP_JZ   = 8'h1e;

    logic [7:0] r_mem [256];
    logic [7:0] r_a, r_b, r_pc, r_ir, r_t;
    logic       r_z, r_c, r_halted;
    state_t     r_state;

    logic [7:0] w_bus_addr, w_addr, w_rd;
    logic [8:0] w_sum, w_diff;
    logic       w_user_we, w_sta_we;
    logic       w_unused_flags;

    function automatic logic f_has_operand(input logic [7:0] opc);
        case (opc)
            OP_MVIA, OP_MVIB, OP_LDA, OP_STA: f_has_operand = 1'b1;
`ifdef PROCESSOR_BRANCH_EN
            OP_JMP, OP_JZ:                    f_has_operand = 1'b1;
`endif
            default:                          f_has_operand = 1'b0;
        endcase
    endfunction

    // LDA/STA put the operand on the bus during EXEC; every other cycle addresses PC.
    assign w_bus_addr = (r_state == S_EXEC && (r_ir == OP_LDA || r_ir == OP_STA)) ? r_t : r_pc;
    assign w_addr     = op ? w_bus_addr : user_address;
    assign w_rd       = r_mem[w_addr];

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    assign w_user_we = !op && user_write_memory;
    assign w_sta_we  = op && (r_state == S_EXEC) && (r_ir == OP_STA);

    // Flags are architectural state without a port; C is never consumed internally.
    assign w_unused_flags = ^{r_c, r_z};

    assign out_data = w_rd;
    assign acc_out  = r_a;
    assign pc_out   = r_pc;
    assign halted   = r_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem <= '{default: 8'h00};
        end else if (w_sta_we) begin
            r_mem[r_t] <= r_a;
        end else if (w_user_we) begin
            r_mem[user_address] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_pc     <= 8'h00;
            r_ir     <= 8'h00;
            r_t      <= 8'h00;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_halted <= 1'b0;
        end else if (!op) begin
            r_state  <= S_IDLE;
            r_pc     <= 8'h00;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_ir    <= w_rd;
                    r_pc    <= r_pc + 8'd1;
                    r_state <= f_has_operand(w_rd) ? S_OPERAND : S_EXEC;
                end
                S_OPERAND: begin
                    r_t     <= w_rd;
                    r_pc    <= r_pc + 8'd1;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    case (r_ir)
                        OP_HLT: begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end
                        OP_ADD: begin
                            r_a <= w_sum[7:0];
                            r_c <= w_sum[8];
                            r_z <= (w_sum[7:0] == 8'h00);
                        end
                        OP_SUB: begin
                            r_a <= w_diff[7:0];
                            r_c <= w_diff[8];
                            r_z <= (w_diff[7:0] == 8'h00);
                        end
                        OP_AND: begin
                            r_a <= r_a & r_b;
                            r_c <= 1'b0;
                            r_z <= ((r_a & r_b) == 8'h00);
                        end
                        OP_XOR: begin
                            r_a <= r_a ^ r_b;
                            r_c <= 1'b0;
                            r_z <= ((r_a ^ r_b) == 8'h00);
                        end
                        OP_MVIA: begin
                            r_a <= r_t;
                            r_z <= (r_t == 8'h00);
                        end
                        OP_MVIB: begin
                            r_b <= r_t;
                        end
                        OP_LDA: begin
                            r_a <= w_rd;
                            r_z <= (w_rd == 8'h00);
                        end
`ifdef PROCESSOR_BRANCH_EN
                        OP_JMP: begin
                            r_pc <= r_t;
                        end
                        OP_JZ: begin
                            if (r_z) r_pc <= r_t;
                        end
`endif
                        default: begin
                        end
                    endcase
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: directed programs plus random straight-line programs
// compared against an instruction-level model of the CPU.
module tb_processor;
    logic       clk = 1'b0;
    logic       reset, op, user_write_memory;
    logic [7:0] in_data, user_address;
    logic [7:0] out_data, acc_out, pc_out;
    logic       halted;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] img     [256];
    logic [7:0] mdl_mem [256];

    processor dut (
        .clk              (clk),
        .reset            (reset),
        .op               (op),
        .in_data          (in_data),
        .user_write_memory(user_write_memory),
        .user_address     (user_address),
        .out_data         (out_data),
        .acc_out          (acc_out),
        .pc_out           (pc_out),
        .halted           (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instruction-level model: executes img until HLT, returning the edge count at which
    // halted rises (1 edge for IDLE->FETCH, then 2 or 3 per instruction).
    task automatic model_run(output int cyc, output logic [7:0] a, output logic [7:0] pc);
        logic [7:0] b, opc, t;
        logic [8:0] s;
        logic       z;
        bit         two;
        mdl_mem = img;
        a = 0; b = 0; pc = 0; z = 0; t = 0; cyc = 1;
        for (int step = 0; step < 5000; step++) begin
            opc = mdl_mem[pc];
            pc  = pc + 8'd1;
            two = (opc == 8'h18 || opc == 8'h19 || opc == 8'h1a || opc == 8'h1c);
`ifdef PROCESSOR_BRANCH_EN
            if (opc == 8'h1d || opc == 8'h1e) two = 1;
`endif
            if (two) begin
                t   = mdl_mem[pc];
                pc  = pc + 8'd1;
                cyc = cyc + 3;
            end else begin
                cyc = cyc + 2;
            end
            case (opc)
                8'h00: return;
                8'h0c: begin s = {1'b0, a} + {1'b0, b}; a = s[7:0]; z = (a == 0); end
                8'h0d: begin a = a - b; z = (a == 0); end
                8'h0e: begin a = a & b; z = (a == 0); end
                8'h0f: begin a = a ^ b; z = (a == 0); end
                8'h18: begin a = t; z = (a == 0); end
                8'h19: b = t;
                8'h1a: begin a = mdl_mem[t]; z = (a == 0); end
                8'h1c: mdl_mem[t] = a;
`ifdef PROCESSOR_BRANCH_EN
                8'h1d: pc = t;
                8'h1e: if (z) pc = t;
`endif
                default: ;
            endcase
        end
        cyc = -1;
    endtask

    task automatic do_reset();
        reset = 1; op = 0; user_write_memory = 0;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic user_write(input logic [7:0] addr, input logic [7:0] data);
        user_address = addr; in_data = data; user_write_memory = 1;
        @(posedge clk); #1;
        user_write_memory = 0;
    endtask

    task automatic load_img();
        for (int i = 0; i < 256; i++)
            if (img[i] != 8'h00) user_write(8'(i), img[i]);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    // Runs the loaded program (with user-port noise that must be ignored) and compares
    // registers, halt timing and the whole memory against the model.
    task automatic run_and_check(input string tag, input int budget, output int n);
        int         exp_cyc, bad;
        logic [7:0] exp_a, exp_pc;
        model_run(exp_cyc, exp_a, exp_pc);
        op = 1; n = 0;
        while (!halted && n < budget) begin
            user_write_memory = 1;
            user_address = 8'($urandom);
            in_data = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        user_write_memory = 0;
        check({tag, ".halt_cycle"}, n, exp_cyc);
        check({tag, ".acc"}, acc_out, exp_a);
        check({tag, ".pc"}, pc_out, exp_pc);
        check({tag, ".halted"}, halted, 1'b1);
        op = 0;
        @(posedge clk); #1;
        check({tag, ".pc_after_drop"}, pc_out, 8'h00);
        check({tag, ".halted_after_drop"}, halted, 1'b0);
        check({tag, ".acc_kept"}, acc_out, exp_a);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            user_address = 8'(i); #1;
            if (out_data !== mdl_mem[i]) bad++;
        end
        check({tag, ".mem_bad_bytes"}, bad, 0);
    endtask

    initial begin
        int n;
        int len, sel;
        logic [7:0] p;
        reset = 0; op = 0; user_write_memory = 0; in_data = 0; user_address = 0;
        do_reset();
        check("reset.acc", acc_out, 8'h00);
        check("reset.pc", pc_out, 8'h00);
        check("reset.halted", halted, 1'b0);
        user_address = 8'hff; #1;
        check("reset.mem_ff", out_data, 8'h00);

        user_write(8'h00, 8'h18);
        user_address = 8'h00; #1;
        check("load.mem00", out_data, 8'h18);
        user_address = 8'h33; #1;
        check("load.unwritten", out_data, 8'h00);

        reset = 1; user_address = 8'h00; in_data = 8'h77; user_write_memory = 1;
        @(posedge clk); #1;
        reset = 0; user_write_memory = 0; #1;
        check("reset_vs_write", out_data, 8'h00);

        // Add/store
        clear_img();
        img[0] = 8'h18; img[1] = 8'haa; img[2] = 8'h19; img[3] = 8'h55;
        img[4] = 8'h0c; img[5] = 8'h1c; img[6] = 8'h1a;
        do_reset(); load_img();
        run_and_check("addsto", 100, n);
        check("addsto.cycles14", n, 14);
        check("addsto.acc_ff", acc_out, 8'hff);
        user_address = 8'h1a; #1;
        check("addsto.mem1a", out_data, 8'hff);

        // Carry/zero
        clear_img();
        img[0] = 8'h18; img[1] = 8'hff; img[2] = 8'h19; img[3] = 8'h01; img[4] = 8'h0c;
        do_reset(); load_img();
        run_and_check("carry", 100, n);
        check("carry.acc00", acc_out, 8'h00);

        // LDA
        clear_img();
        img[0] = 8'h1a; img[1] = 8'h40; img[8'h40] = 8'h3c;
        do_reset(); load_img();
        run_and_check("lda", 100, n);
        check("lda.acc3c", acc_out, 8'h3c);

        // Branch (or NOP decode when branches are disabled)
        clear_img();
        img[0] = 8'h18; img[1] = 8'h00; img[2] = 8'h1e; img[3] = 8'h06;
        img[4] = 8'h18; img[5] = 8'h11;
        do_reset(); load_img();
        run_and_check("branch", 100, n);
`ifdef PROCESSOR_BRANCH_EN
        check("branch.acc", acc_out, 8'h00);
`else
        check("branch.acc", acc_out, 8'h11);
`endif

        // PC wrap with operand fetched from 0xff; second pass self-modifies a HLT at 0x05
        for (int i = 0; i < 256; i++) img[i] = 8'h01;
        img[0] = 8'h19; img[1] = 8'h01; img[2] = 8'h0f; img[3] = 8'h1c; img[4] = 8'h05;
        img[8'hfe] = 8'h18; img[8'hff] = 8'h01;
        do_reset(); load_img();
        run_and_check("wrap", 2000, n);

        // Abort mid-program keeps A and memory, returns PC to 0
        clear_img();
        img[0] = 8'h18; img[1] = 8'haa; img[2] = 8'h19; img[3] = 8'h55;
        img[4] = 8'h0c; img[5] = 8'h1c; img[6] = 8'h1a;
        do_reset(); load_img();
        op = 1;
        repeat (5) @(posedge clk);
        #1 op = 0;
        @(posedge clk); #1;
        check("abort.pc", pc_out, 8'h00);
        check("abort.halted", halted, 1'b0);
        check("abort.acc", acc_out, 8'haa);
        user_address = 8'h1a; #1;
        check("abort.mem1a", out_data, 8'h00);
        user_address = 8'h01; #1;
        check("abort.mem01", out_data, 8'haa);

        // Reset after STA has written mem[0x1a]
        op = 1;
        repeat (13) @(posedge clk);
        #1 reset = 1; op = 0;
        @(posedge clk); #1;
        reset = 0;
        check("rstrun.acc", acc_out, 8'h00);
        check("rstrun.pc", pc_out, 8'h00);
        check("rstrun.halted", halted, 1'b0);
        user_address = 8'h1a; #1;
        check("rstrun.mem1a", out_data, 8'h00);
        user_address = 8'h00; #1;
        check("rstrun.mem00", out_data, 8'h00);

        // Random straight-line programs
        for (int r = 0; r < 20; r++) begin
            clear_img();
            for (int k = 8'hc0; k < 8'hd0; k++) img[k] = 8'($urandom);
            p = 0;
            len = $urandom_range(3, 20);
            for (int k = 0; k < len; k++) begin
                sel = $urandom_range(0, 8);
                case (sel)
                    0: begin img[p] = 8'h18; img[p+1] = 8'($urandom); p = p + 2; end
                    1: begin img[p] = 8'h19; img[p+1] = 8'($urandom); p = p + 2; end
                    2: begin img[p] = 8'h0c; p = p + 1; end
                    3: begin img[p] = 8'h0d; p = p + 1; end
                    4: begin img[p] = 8'h0e; p = p + 1; end
                    5: begin img[p] = 8'h0f; p = p + 1; end
                    6: begin img[p] = 8'h1a; img[p+1] = 8'($urandom); p = p + 2; end
                    7: begin img[p] = 8'h1c; img[p+1] = 8'($urandom_range(8'h80, 8'hff)); p = p + 2; end
                    default: begin img[p] = 8'($urandom_range(8'h20, 8'hff)); p = p + 1; end
                endcase
            end
            do_reset(); load_img();
            run_and_check($sformatf("rand%0d", r), 200, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
